// File: rtl/reg_writeback_queue_pkg.sv
// Shared defaults and types for the register-file writeback queue.
package wb_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/reg_writeback_queue_fifo.sv
// In-order storage for pending writebacks: up to two pushes and one pop per edge.
// Entries are exposed oldest-first for the hazard scan; data view only with WB_FWD_EN.
module wb_fifo #(
  parameter int DEPTH  = 4,
  parameter int REG_AW = 4,
  parameter int DATA_W = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          wr0_en_i,
  input  logic [REG_AW+DATA_W-1:0]      wr0_data_i,
  input  logic                          wr1_en_i,
  input  logic [REG_AW+DATA_W-1:0]      wr1_data_i,
  input  logic                          rd_en_i,
  output logic [REG_AW+DATA_W-1:0]      rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
  output logic [DEPTH-1:0]              valid_o,
`ifdef WB_FWD_EN
  output logic [DEPTH*DATA_W-1:0]       data_o,
`endif
  output logic [DEPTH*REG_AW-1:0]       reg_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [REG_AW+DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d;

  always_comb begin
    head_d  = head_q + PW'(rd_en_i);
    tail_d  = tail_q + PW'(wr0_en_i) + PW'(wr1_en_i);
    count_d = count_q + CW'(wr0_en_i) + CW'(wr1_en_i) - CW'(rd_en_i);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Second push of the same edge lands one slot behind the first; wrap is natural.
  always_ff @(posedge clock) begin
    if (wr0_en_i) mem_q[tail_q] <= wr0_data_i;
    if (wr1_en_i) mem_q[tail_q + PW'(1)] <= wr1_data_i;
  end

  assign rd_data_o = mem_q[head_q];
  assign count_o   = count_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ord
    logic [PW-1:0] slot;
    assign slot        = head_q + PW'(gi);
    assign valid_o[gi] = CW'(gi) < count_q;
    assign reg_o[gi*REG_AW +: REG_AW] = mem_q[slot][REG_AW+DATA_W-1 -: REG_AW];
`ifdef WB_FWD_EN
    assign data_o[gi*DATA_W +: DATA_W] = mem_q[slot][DATA_W-1:0];
`endif
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// Merges memory and ALU writebacks into one register-file write per cycle, with RAW hazard flags.
// Define WB_FWD_EN to add fwd1/fwd2 outputs carrying the youngest pending value for rs1/rs2.
module reg_writeback_queue #(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int REG_AW = wb_pkg::REG_AW,
  parameter int DEPTH  = wb_pkg::DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_AW-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              reg_write,
  output logic [REG_AW-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic              hazard1,
  output logic              hazard2,
`ifdef WB_FWD_EN
  output logic              fwd1_valid,
  output logic [DATA_W-1:0] fwd1_data,
  output logic              fwd2_valid,
  output logic [DATA_W-1:0] fwd2_data,
`endif
  output logic              idle
);
  import wb_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [REG_AW-1:0] ZERO_REG = REG_AW'(REG_ZERO);

  logic [CW-1:0]              fifo_count, free;
  logic [DEPTH-1:0]           ord_valid, hit1, hit2;
  logic [DEPTH*REG_AW-1:0]    ord_reg;
  logic [REG_AW+DATA_W-1:0]   head_entry, wr0_data, wr1_data;
  logic                       mem_push, alu_push, wr0_en, wr1_en, pop;
  logic                       reg_write_q;
  logic [REG_AW-1:0]          write_reg_q;
  logic [DATA_W-1:0]          write_data_q;
`ifdef WB_FWD_EN
  logic [DEPTH*DATA_W-1:0]    ord_data;
`endif

  // Space comes from registered count only; a same-edge pop never frees a slot early.
  assign free      = CW'(DEPTH) - fifo_count;
  assign mem_ready = (free != '0);
  assign alu_ready = (free >= CW'(2)) || ((free != '0) && !mem_valid);

  // Register 0 requests finish the handshake but never occupy a slot.
  assign mem_push = mem_valid && mem_ready && (mem_reg != ZERO_REG);
  assign alu_push = alu_valid && alu_ready && (alu_reg != ZERO_REG);
  assign wr0_en   = mem_push || alu_push;
  assign wr0_data = mem_push ? {mem_reg, mem_data} : {alu_reg, alu_data};
  assign wr1_en   = mem_push && alu_push;
  assign wr1_data = {alu_reg, alu_data};
  assign pop      = (fifo_count != '0);

  wb_fifo #(.DEPTH(DEPTH), .REG_AW(REG_AW), .DATA_W(DATA_W)) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr0_en_i   (wr0_en),
    .wr0_data_i (wr0_data),
    .wr1_en_i   (wr1_en),
    .wr1_data_i (wr1_data),
    .rd_en_i    (pop),
    .rd_data_o  (head_entry),
    .count_o    (fifo_count),
    .valid_o    (ord_valid),
`ifdef WB_FWD_EN
    .data_o     (ord_data),
`endif
    .reg_o      (ord_reg)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      reg_write_q <= pop;
      if (pop) begin
        write_reg_q  <= head_entry[REG_AW+DATA_W-1 -: REG_AW];
        write_data_q <= head_entry[DATA_W-1:0];
      end
    end
  end

  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    assign hit1[gi] = ord_valid[gi] && (ord_reg[gi*REG_AW +: REG_AW] == rs1);
    assign hit2[gi] = ord_valid[gi] && (ord_reg[gi*REG_AW +: REG_AW] == rs2);
  end

  assign hazard1 = (rs1 != ZERO_REG) && ((|hit1) || (reg_write_q && (write_reg_q == rs1)));
  assign hazard2 = (rs2 != ZERO_REG) && ((|hit2) || (reg_write_q && (write_reg_q == rs2)));
  assign idle    = (fifo_count == '0) && !reg_write_q;

`ifdef WB_FWD_EN
  // Output stage is the oldest pending write; later queue entries override it.
  function automatic logic [DATA_W-1:0] youngest(
    input logic [REG_AW-1:0]       rs,
    input logic [DEPTH-1:0]        v,
    input logic [DEPTH*REG_AW-1:0] r,
    input logic [DEPTH*DATA_W-1:0] d,
    input logic [DATA_W-1:0]       stage
  );
    logic [DATA_W-1:0] res;
    res = stage;
    for (int k = 0; k < DEPTH; k++) begin
      if (v[k] && (r[k*REG_AW +: REG_AW] == rs)) res = d[k*DATA_W +: DATA_W];
    end
    return res;
  endfunction

  assign fwd1_valid = hazard1;
  assign fwd2_valid = hazard2;
  assign fwd1_data  = youngest(rs1, ord_valid, ord_reg, ord_data, write_data_q);
  assign fwd2_data  = youngest(rs2, ord_valid, ord_reg, ord_data, write_data_q);
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue; a DEPTH=2 instance covers the full-FIFO case.
module tb_reg_writeback_queue;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;

  logic        mem_valid, mem_ready, alu_valid, alu_ready;
  logic [3:0]  mem_reg, alu_reg, write_reg, rs1, rs2;
  logic [15:0] mem_data, alu_data, write_data;
  logic        reg_write, hazard1, hazard2, idle;
`ifdef WB_FWD_EN
  logic        fwd1_valid, fwd2_valid;
  logic [15:0] fwd1_data, fwd2_data;
  logic        s_fwd1_valid, s_fwd2_valid;
  logic [15:0] s_fwd1_data, s_fwd2_data;
`endif

  logic        s_mem_valid, s_mem_ready, s_alu_valid, s_alu_ready;
  logic [3:0]  s_mem_reg, s_alu_reg, s_write_reg, s_rs1, s_rs2;
  logic [15:0] s_mem_data, s_alu_data, s_write_data;
  logic        s_reg_write, s_hazard1, s_hazard2, s_idle;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  reg_writeback_queue dut (
    .clock(clock), .reset_n(reset_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .rs1(rs1), .rs2(rs2), .hazard1(hazard1), .hazard2(hazard2),
`ifdef WB_FWD_EN
    .fwd1_valid(fwd1_valid), .fwd1_data(fwd1_data),
    .fwd2_valid(fwd2_valid), .fwd2_data(fwd2_data),
`endif
    .idle(idle)
  );

  reg_writeback_queue #(.DEPTH(2)) dut_small (
    .clock(clock), .reset_n(reset_n),
    .mem_valid(s_mem_valid), .mem_ready(s_mem_ready), .mem_reg(s_mem_reg), .mem_data(s_mem_data),
    .alu_valid(s_alu_valid), .alu_ready(s_alu_ready), .alu_reg(s_alu_reg), .alu_data(s_alu_data),
    .reg_write(s_reg_write), .write_reg(s_write_reg), .write_data(s_write_data),
    .rs1(s_rs1), .rs2(s_rs2), .hazard1(s_hazard1), .hazard2(s_hazard2),
`ifdef WB_FWD_EN
    .fwd1_valid(s_fwd1_valid), .fwd1_data(s_fwd1_data),
    .fwd2_valid(s_fwd2_valid), .fwd2_data(s_fwd2_data),
`endif
    .idle(s_idle)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_mem(input logic v, input logic [3:0] r, input logic [15:0] d);
    mem_valid = v; mem_reg = r; mem_data = d;
  endtask

  task automatic drive_alu(input logic v, input logic [3:0] r, input logic [15:0] d);
    alu_valid = v; alu_reg = r; alu_data = d;
  endtask

  initial begin
    drive_mem(0, 0, 0); drive_alu(0, 0, 0); rs1 = 0; rs2 = 0;
    s_mem_valid = 0; s_mem_reg = 0; s_mem_data = 0;
    s_alu_valid = 0; s_alu_reg = 0; s_alu_data = 0; s_rs1 = 0; s_rs2 = 0;

    // Reset state
    repeat (2) step();
    @(negedge clock) reset_n = 1'b1;
    step();
    check("rst_reg_write", reg_write, 0);
    check("rst_write_reg", write_reg, 0);
    check("rst_write_data", write_data, 0);
    check("rst_idle", idle, 1);
    check("rst_mem_ready", mem_ready, 1);
    check("rst_alu_ready", alu_ready, 1);

    // Single ALU write to r5
    drive_alu(1, 4'd5, 16'h1234); rs1 = 4'd5; #1;
    check("single_alu_ready", alu_ready, 1);
    check("single_haz_before", hazard1, 0);
    step(); drive_alu(0, 0, 0); #1;
    check("single_e0_reg_write", reg_write, 0);
    check("single_e0_hazard1", hazard1, 1);
    check("single_e0_idle", idle, 0);
    step();
    check("single_e1_reg_write", reg_write, 1);
    check("single_e1_write_reg", write_reg, 5);
    check("single_e1_write_data", write_data, 16'h1234);
    check("single_e1_hazard1", hazard1, 1);
    step();
    check("single_e2_reg_write", reg_write, 0);
    check("single_e2_idle", idle, 1);
    check("single_e2_hazard1", hazard1, 0);
    check("single_e2_hold_reg", write_reg, 5);

    // Register 0 is acknowledged and dropped
    drive_alu(1, 4'd0, 16'hFFFF); rs1 = 4'd0; #1;
    check("r0_alu_ready", alu_ready, 1);
    step(); drive_alu(0, 0, 0); #1;
    check("r0_idle", idle, 1);
    check("r0_hazard1", hazard1, 0);
    step();
    check("r0_reg_write", reg_write, 0);
    check("r0_hold_data", write_data, 16'h1234);

    // Simultaneous mem/alu: mem goes first
    drive_mem(1, 4'd2, 16'hAAAA); drive_alu(1, 4'd3, 16'h5555); rs1 = 4'd2; rs2 = 4'd3; #1;
    check("sim_mem_ready", mem_ready, 1);
    check("sim_alu_ready", alu_ready, 1);
    step(); drive_mem(0, 0, 0); drive_alu(0, 0, 0); #1;
    check("sim_e0_hazard1", hazard1, 1);
    check("sim_e0_hazard2", hazard2, 1);
    check("sim_e0_reg_write", reg_write, 0);
    step();
    check("sim_e1_reg_write", reg_write, 1);
    check("sim_e1_write_reg", write_reg, 2);
    check("sim_e1_write_data", write_data, 16'hAAAA);
    step();
    check("sim_e2_write_reg", write_reg, 3);
    check("sim_e2_write_data", write_data, 16'h5555);
    check("sim_e2_hazard1", hazard1, 0);
    check("sim_e2_hazard2", hazard2, 1);
    step();
    check("sim_e3_reg_write", reg_write, 0);
    check("sim_e3_idle", idle, 1);

    // Build count 3 so free == 1; only mem is accepted then
    drive_mem(1, 4'd6, 16'h0606); drive_alu(1, 4'd7, 16'h0707); #1;
    step(); drive_mem(1, 4'd8, 16'h0808); drive_alu(1, 4'd9, 16'h0909); #1;
    check("free2_alu_ready", alu_ready, 1);
    step(); drive_mem(1, 4'd10, 16'h0A0A); drive_alu(1, 4'd11, 16'h0B0B); #1;
    check("free1_mem_ready", mem_ready, 1);
    check("free1_alu_ready", alu_ready, 0);
    check("free1_write_reg", write_reg, 6);
    step(); drive_mem(0, 0, 0); drive_alu(0, 0, 0); rs1 = 4'd11; #1;
    check("free1b_write_reg", write_reg, 7);
    check("free1b_alu_ready_nomem", alu_ready, 1);
    check("free1b_r11_not_queued", hazard1, 0);
    step();
    check("drain_w8", write_reg, 8);
    step();
    check("drain_w9", write_reg, 9);
    step();
    check("drain_w10", write_reg, 10);
    check("drain_d10", write_data, 16'h0A0A);
    step();
    check("drain_reg_write", reg_write, 0);
    check("drain_idle", idle, 1);

    // DEPTH=2 instance: fill completely
    s_mem_valid = 1; s_mem_reg = 4'd1; s_mem_data = 16'h0011;
    s_alu_valid = 1; s_alu_reg = 4'd2; s_alu_data = 16'h0022; #1;
    check("small_mem_ready0", s_mem_ready, 1);
    check("small_alu_ready0", s_alu_ready, 1);
    step();
    check("full_mem_ready", s_mem_ready, 0);
    check("full_alu_ready", s_alu_ready, 0);
    step();
    check("full_e1_write_reg", s_write_reg, 1);
    check("full_e1_write_data", s_write_data, 16'h0011);
    check("full_e1_mem_ready", s_mem_ready, 1);
    check("full_e1_alu_ready", s_alu_ready, 0);
    s_mem_valid = 0; s_alu_valid = 0;
    step();
    check("full_e2_write_reg", s_write_reg, 2);
    check("full_e2_write_data", s_write_data, 16'h0022);
    step();
    check("full_e3_idle", s_idle, 1);

`ifdef WB_FWD_EN
    // Youngest of two pending writes to r4 is forwarded
    drive_mem(1, 4'd4, 16'h0001); drive_alu(1, 4'd4, 16'h0002); rs2 = 4'd4; #1;
    step(); drive_mem(0, 0, 0); drive_alu(0, 0, 0); #1;
    check("fwd_e0_valid", fwd2_valid, 1);
    check("fwd_e0_data", fwd2_data, 16'h0002);
    check("fwd_e0_hazard2", hazard2, 1);
    step();
    check("fwd_e1_write_data", write_data, 16'h0001);
    check("fwd_e1_data", fwd2_data, 16'h0002);
    step();
    check("fwd_e2_valid", fwd2_valid, 1);
    check("fwd_e2_data", fwd2_data, 16'h0002);
    step();
    check("fwd_e3_valid", fwd2_valid, 0);
    rs2 = 4'd0;
`endif

    // Asynchronous reset with three entries queued
    drive_mem(1, 4'd12, 16'h0C0C); drive_alu(1, 4'd13, 16'h0D0D); #1;
    step(); drive_mem(1, 4'd14, 16'h0E0E); drive_alu(1, 4'd15, 16'h0F0F); #1;
    step(); drive_mem(0, 0, 0); drive_alu(0, 0, 0); rs1 = 4'd14; #1;
    check("pre_rst_hazard1", hazard1, 1);
    check("pre_rst_write_reg", write_reg, 12);
    check("pre_rst_idle", idle, 0);
    reset_n = 1'b0; #1;
    check("arst_reg_write", reg_write, 0);
    check("arst_write_reg", write_reg, 0);
    check("arst_write_data", write_data, 0);
    check("arst_idle", idle, 1);
    check("arst_hazard1", hazard1, 0);
    @(negedge clock) reset_n = 1'b1;
    step();
    check("post_rst_mem_ready", mem_ready, 1);
    check("post_rst_alu_ready", alu_ready, 1);
    check("post_rst_idle", idle, 1);
    check("post_rst_reg_write", reg_write, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
- Writer-side counterpart of the 16x16 register file: collects writeback results from the memory and ALU paths and drives the file's write port (reg_write, write_reg, write_data), one register per cycle.
- Buffers requests in a small in-order FIFO with a registered output stage.
- Reports read-after-write hazards for the two register-file read addresses so the control unit can stall.

Parameters:
- DATA_W, 16, data width; matches register width.
- REG_AW, 4, register-number width (16 registers).
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clock  in  1  rising-edge clock, shared with the register file
- reset_n  in  1  asynchronous, active-low reset
- mem_valid  in  1  memory-path writeback request
- mem_ready  out  1  memory request accepted when valid && ready at the edge
- mem_reg  in  REG_AW  destination register
- mem_data  in  DATA_W  write value
- alu_valid  in  1  ALU-path writeback request
- alu_ready  out  1  ALU request accepted when valid && ready at the edge
- alu_reg  in  REG_AW  destination register
- alu_data  in  DATA_W  write value
- reg_write  out  1  write enable to register file
- write_reg  out  REG_AW  register number to write
- write_data  out  DATA_W  data to write
- rs1, rs2  in  REG_AW  current read addresses (same values as the register file's Read1/Read2)
- hazard1, hazard2  out  1  rs1/rs2 has a pending write
- idle  out  1  FIFO empty and reg_write low

Behaviour:
Reset
- reset_n low asynchronously clears count, head and tail pointers, reg_write, write_reg and write_data to 0.
- Requests held in the FIFO at reset are lost.

Free slots and ready
- free = DEPTH - count, counted from registered state only. Pops in the same cycle do not add space.
- mem_ready = (free >= 1).
- alu_ready = (free >= 2) || (free >= 1 && !mem_valid).

Enqueue
- Memory has priority.
- If both requests are accepted at the same edge, the mem entry is enqueued before the alu entry.

Register 0
- A request to register 0 completes its handshake but is discarded: not enqueued, and no free slot is consumed.

Output stage
- At each edge where count > 0, the head is popped into the output registers and reg_write = 1.
- Otherwise reg_write = 0, and write_reg/write_data hold their last values.
- Push and pop at the same edge are legal. Count changes by (pushes - pop).

Latency
- A request accepted into an empty FIFO at edge k drives reg_write from edge k+1.
- The register file captures it at edge k+2.
- Throughput is one write per cycle. Order is strict FIFO.

Hazards
- hazardN = 1 when rsN != 0 and rsN matches either any valid FIFO entry, or write_reg while reg_write = 1.
- Purely combinational from state and rsN.

Idle
- idle = (count == 0) && !reg_write.

Boundary conditions
- With FIFO full, both ready signals are 0.
- With free == 1, only one request is accepted, memory first.
- Pointer wrap is modulo DEPTH.
- count never exceeds DEPTH.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined: adds outputs fwd1_valid/fwd1_data and fwd2_valid/fwd2_data. fwdN_valid equals hazardN. fwdN_data is the data of the youngest pending write to rsN, searched tail to head, then the output stage. Hazard outputs are unchanged.
- Undefined: these ports and the search logic are absent.

Decomposition:
- Package wb_pkg: DATA_W, REG_AW, DEPTH defaults; typedef wb_entry_t {reg, data}; constant REG_ZERO = 0.
- One natural sub-module: wb_fifo, a DEPTH-entry storage array with push/pop and an entry-valid vector exposed for the hazard/forward scan.
- Arbitration, output stage and hazard logic stay in the top module.

Test Plan:
- Reset: reset_n low mid-stream with 3 entries queued -> reg_write=0, write_reg=0, write_data=0, idle=1, count=0 immediately. After release, mem_ready=1 and alu_ready=1.
- Single write: alu_valid with reg 5, data 0x1234 accepted at edge 0 -> reg_write=1, write_reg=5, write_data=0x1234 after edge 1. hazard1=1 for rs1=5 during cycles 0..1. idle=1 after edge 2.
- Simultaneous: mem (r2, 0xAAAA) and alu (r3, 0x5555) accepted at the same edge -> writes issue r2 then r3 on consecutive cycles.
- Full: 4 mem requests with no drain opportunity -> both readies 0. With free=1 and both valid -> only mem accepted, alu_ready=0.
- Register 0: alu request to r0, data 0xFFFF -> alu_ready handshake completes, reg_write stays 0, hazard1=0 for rs1=0.
- WB_FWD_EN: queue r4=0x0001 then r4=0x0002 -> with rs2=4, fwd2_valid=1 and fwd2_data=0x0002. After both writes drain, fwd2_valid=0.
